// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_RUN,
      ST_ERR
   } loader_state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_CSUM    = 2'd3;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_prog_loader_timeout.sv
// Inter-byte watchdog: counts clocks since the last clear while enabled and
// flags expiry on the clock that would reach TIMEOUT_CLKS.
module loader_timeout #(
   parameter int unsigned TIMEOUT_CLKS = 100000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CLKS - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear || !enable) begin
         count_d = '0;
      end else if (count_q < LIMIT) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry is reported one clock early so the FSM transitions on the
   // TIMEOUT_CLKS-th clock after the last byte.
   assign expired = enable && (count_q >= LIMIT);

endmodule

// File: rtl/uart_prog_loader.sv
// Packet parser that streams a framed UART payload into program memory and
// holds the CPU in reset until the checksum has been verified.
module uart_prog_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned ADDR_W       = 8,
   parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
   parameter int unsigned TIMEOUT_CLKS = 100000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx_done,
   input  logic [7:0]        rx_byte,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              load_ok,
   output logic              load_err,
   output logic [1:0]        err_code
);

   localparam int unsigned MAX_LEN = (1 << ADDR_W) - 1;

   loader_state_e     state_q, state_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              busy_q, busy_d;
   logic              load_ok_q, load_ok_d;
   logic              load_err_q, load_err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [7:0]        checksum_q, checksum_d;
   logic [7:0]        remaining_q, remaining_d;

   logic              in_packet;
   logic              tmo_expired;
   logic              fail;
   logic [1:0]        fail_code;

   assign in_packet = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                      (state_q == ST_CSUM);

   loader_timeout #(
      .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .enable (in_packet),
      .clear  (rx_done),
      .expired(tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      wr_addr_d   = wr_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_reset_d = cpu_reset_q;
      busy_d      = busy_q;
      load_ok_d   = load_ok_q;
      load_err_d  = load_err_q;
      err_code_d  = err_code_q;
      checksum_d  = checksum_q;
      remaining_d = remaining_q;
      fail        = 1'b0;
      fail_code   = ERR_NONE;

      case (state_q)
         ST_IDLE, ST_RUN, ST_ERR: begin
            if (rx_done && (rx_byte == SYNC_BYTE)) begin
               state_d     = ST_LEN;
               cpu_reset_d = 1'b1;
               busy_d      = 1'b1;
               load_ok_d   = 1'b0;
               load_err_d  = 1'b0;
               err_code_d  = ERR_NONE;
               checksum_d  = '0;
               mem_addr_d  = '0;
               wr_addr_d   = '0;
            end
         end
         ST_LEN: begin
            if (rx_done) begin
               if ((rx_byte == 8'd0) || (32'(rx_byte) > MAX_LEN)) begin
                  fail      = 1'b1;
                  fail_code = ERR_LEN;
               end else begin
                  remaining_d = rx_byte;
                  state_d     = ST_DATA;
               end
            end else if (tmo_expired) begin
               fail      = 1'b1;
               fail_code = ERR_TIMEOUT;
            end
         end
         ST_DATA: begin
            if (rx_done) begin
               mem_we_d    = 1'b1;
               mem_wdata_d = rx_byte;
               mem_addr_d  = wr_addr_q;
               wr_addr_d   = wr_addr_q + 1'b1;
               checksum_d  = checksum_q + rx_byte;
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1) begin
                  state_d = ST_CSUM;
               end
            end else if (tmo_expired) begin
               fail      = 1'b1;
               fail_code = ERR_TIMEOUT;
            end
         end
         ST_CSUM: begin
            if (rx_done) begin
               if (rx_byte == checksum_q) begin
                  state_d     = ST_RUN;
                  load_ok_d   = 1'b1;
                  cpu_reset_d = 1'b0;
                  busy_d      = 1'b0;
               end else begin
                  fail      = 1'b1;
                  fail_code = ERR_CSUM;
               end
            end else if (tmo_expired) begin
               fail      = 1'b1;
               fail_code = ERR_TIMEOUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (fail) begin
         state_d     = ST_ERR;
         load_err_d  = 1'b1;
         busy_d      = 1'b0;
         cpu_reset_d = 1'b1;
         err_code_d  = fail_code;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         wr_addr_q   <= '0;
         mem_wdata_q <= '0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         load_ok_q   <= 1'b0;
         load_err_q  <= 1'b0;
         err_code_q  <= ERR_NONE;
         checksum_q  <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         wr_addr_q   <= wr_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         load_ok_q   <= load_ok_d;
         load_err_q  <= load_err_d;
         err_code_q  <= err_code_d;
         checksum_q  <= checksum_d;
         remaining_q <= remaining_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_reset = cpu_reset_q;
   assign busy      = busy_q;
   assign load_ok   = load_ok_q;
   assign load_err  = load_err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a 50-clock inter-byte timeout.
module tb_uart_prog_loader;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx_done = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_reset;
   logic       busy;
   logic       load_ok;
   logic       load_err;
   logic [1:0] err_code;

   int checks = 0;
   int errors = 0;
   int we_count = 0;
   int double_we = 0;
   logic prev_we = 1'b0;
   int base;

   uart_prog_loader #(
      .ADDR_W      (8),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CLKS(50)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .rx_done  (rx_done),
      .rx_byte  (rx_byte),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_reset(cpu_reset),
      .busy     (busy),
      .load_ok  (load_ok),
      .load_err (load_err),
      .err_code (err_code)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_we) we_count <= we_count + 1;
      if (mem_we && prev_we) double_we <= double_we + 1;
      prev_we <= mem_we;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Strobe one byte; returns at the negedge right after the sampling edge.
   task automatic send(input logic [7:0] b);
      @(negedge clock);
      rx_byte = b;
      rx_done = 1'b1;
      @(negedge clock);
      rx_done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic sendi(input logic [7:0] b);
      send(b);
      idle(2);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " cpu_reset"}, 32'(cpu_reset), 32'd1);
      check({tag, " mem_we"}, 32'(mem_we), 32'd0);
      check({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " load_ok"}, 32'(load_ok), 32'd0);
      check({tag, " load_err"}, 32'(load_err), 32'd0);
      check({tag, " err_code"}, 32'(err_code), 32'd0);
   endtask

   task automatic check_write(input string tag, input logic [7:0] a, input logic [7:0] d);
      check({tag, " we"}, 32'(mem_we), 32'd1);
      check({tag, " addr"}, 32'(mem_addr), 32'(a));
      check({tag, " data"}, 32'(mem_wdata), 32'(d));
   endtask

   initial begin
      // Reset
      idle(2);
      check_reset_vals("reset");
      reset = 1'b0;
      idle(2);

      // Normal load
      send(8'hA5);
      check("norm busy", 32'(busy), 32'd1);
      check("norm cpu_reset", 32'(cpu_reset), 32'd1);
      idle(2);
      sendi(8'h03);
      send(8'h11);
      check_write("norm w0", 8'h00, 8'h11);
      @(negedge clock);
      check("norm we single", 32'(mem_we), 32'd0);
      check("norm addr hold", 32'(mem_addr), 32'd0);
      idle(2);
      send(8'h22);
      check_write("norm w1", 8'h01, 8'h22);
      idle(2);
      send(8'h33);
      check_write("norm w2", 8'h02, 8'h33);
      idle(2);
      check("norm cpu_reset pre", 32'(cpu_reset), 32'd1);
      send(8'h66);
      check("norm cpu_reset", 32'(cpu_reset), 32'd0);
      check("norm load_ok", 32'(load_ok), 32'd1);
      check("norm err_code", 32'(err_code), 32'd0);
      check("norm busy end", 32'(busy), 32'd0);
      idle(2);

      // Reload from RUN, which turns into a checksum error
      send(8'hA5);
      check("reload cpu_reset", 32'(cpu_reset), 32'd1);
      check("reload load_ok", 32'(load_ok), 32'd0);
      check("reload busy", 32'(busy), 32'd1);
      idle(2);
      base = we_count;
      sendi(8'h02);
      sendi(8'h10);
      sendi(8'h20);
      sendi(8'h31);
      check("csum writes", 32'(we_count - base), 32'd2);
      check("csum load_err", 32'(load_err), 32'd1);
      check("csum err_code", 32'(err_code), 32'd3);
      check("csum cpu_reset", 32'(cpu_reset), 32'd1);
      check("csum busy", 32'(busy), 32'd0);

      // Recovery
      sendi(8'hA5);
      check("recov err clr", 32'(load_err), 32'd0);
      sendi(8'h01);
      send(8'h7F);
      check_write("recov w0", 8'h00, 8'h7F);
      idle(2);
      sendi(8'h7F);
      check("recov load_ok", 32'(load_ok), 32'd1);
      check("recov cpu_reset", 32'(cpu_reset), 32'd0);

      // Bad length
      base = we_count;
      sendi(8'hA5);
      sendi(8'h00);
      check("len err_code", 32'(err_code), 32'd1);
      check("len load_err", 32'(load_err), 32'd1);
      sendi(8'h33);
      check("len ignore err_code", 32'(err_code), 32'd1);
      check("len no writes", 32'(we_count - base), 32'd0);

      // Timeout: expiry exactly 50 clocks after the last strobe
      sendi(8'hA5);
      sendi(8'h04);
      send(8'h01);
      check_write("tmo w0", 8'h00, 8'h01);
      idle(49);
      check("tmo alive 49", 32'(load_err), 32'd0);
      check("tmo busy 49", 32'(busy), 32'd1);
      idle(1);
      check("tmo load_err", 32'(load_err), 32'd1);
      check("tmo err_code", 32'(err_code), 32'd2);
      check("tmo cpu_reset", 32'(cpu_reset), 32'd1);
      idle(2);

      // Timeout boundary: byte on clock 50 wins
      sendi(8'hA5);
      sendi(8'h04);
      send(8'h01);
      idle(48);
      send(8'h02);
      check_write("tmob w1", 8'h01, 8'h02);
      check("tmob alive", 32'(load_err), 32'd0);
      idle(2);
      sendi(8'h03);
      sendi(8'h04);
      sendi(8'h0A);
      check("tmob load_ok", 32'(load_ok), 32'd1);

      // Reset mid-packet
      sendi(8'hA5);
      sendi(8'h04);
      sendi(8'hAA);
      sendi(8'hBB);
      check("rst pre addr", 32'(mem_addr), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_reset_vals("midrst");
      reset = 1'b0;
      idle(2);
      sendi(8'hA5);
      sendi(8'h01);
      send(8'h5C);
      check_write("postrst w0", 8'h00, 8'h5C);
      idle(2);
      sendi(8'h5C);
      check("postrst load_ok", 32'(load_ok), 32'd1);

      // Payload bytes equal to sync
      sendi(8'hA5);
      sendi(8'h02);
      send(8'hA5);
      check_write("sync w0", 8'h00, 8'hA5);
      idle(2);
      send(8'hA5);
      check_write("sync w1", 8'h01, 8'hA5);
      idle(2);
      sendi(8'h4A);
      check("sync load_ok", 32'(load_ok), 32'd1);
      check("sync err_code", 32'(err_code), 32'd0);

      idle(2);
      check("no back-to-back we", 32'(double_we), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Controller that sequences the UART receiver's byte stream into the MC14500B program memory and holds the CPU in reset while a program is loaded.
- Parses a framed packet (sync, length, payload, checksum), issues one memory write per payload byte, and verifies the checksum.
- Releases the CPU only when the checksum matches; a sync byte received at any idle point restarts loading.

Parameters:
- ADDR_W, 8, program memory address width; payload length is limited to 2**ADDR_W-1 bytes.
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT_CLKS, 100000, maximum clocks between consecutive bytes inside a packet.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_done  in  1  one-cycle strobe from the UART receiver: rx_byte is valid
- rx_byte  in  8  received byte
- mem_we  out  1  program memory write strobe, one cycle
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- cpu_reset  out  1  high holds the CPU in reset
- busy  out  1  high while a packet is being received
- load_ok  out  1  level: the last load succeeded
- load_err  out  1  level: the last load failed
- err_code  out  2  0 none, 1 bad length, 2 timeout, 3 checksum mismatch

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, cpu_reset=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, load_ok=0, load_err=0, err_code=0, checksum=0, timeout counter=0.
- Reset asserted mid-packet aborts the load immediately; partial memory contents are left as written.
- States: IDLE, LEN, DATA, CSUM, RUN, ERR. Decisions are made only on cycles where rx_done=1; bytes with rx_done=0 are ignored.
- IDLE, RUN, ERR: rx_byte==SYNC_BYTE goes to LEN. On that transition:
  - set cpu_reset=1, busy=1;
  - clear load_ok, load_err, err_code, checksum, mem_addr and the timeout counter.
  - Any other byte is ignored.
- LEN:
  - len = rx_byte.
  - len==0 or len > 2**ADDR_W-1 goes to ERR with err_code=1.
  - Otherwise store remaining=len and go to DATA.
- DATA, per byte:
  - mem_we=1 on the next cycle with mem_wdata=rx_byte and mem_addr=current address;
  - the address increments after the write;
  - checksum += rx_byte (8-bit, wraps mod 256);
  - remaining decrements; on the last byte go to CSUM.
  - Write latency: exactly one cycle after rx_done. mem_we is never high for two consecutive cycles.
  - mem_addr holds its last value between writes.
- CSUM:
  - rx_byte==checksum goes to RUN with load_ok=1, cpu_reset=0, busy=0.
  - Otherwise go to ERR with err_code=3.
  - A SYNC_BYTE value here is treated as checksum data, not as a restart.
- Timeout:
  - The counter runs in LEN, DATA and CSUM and clears on every rx_done.
  - Reaching TIMEOUT_CLKS goes to ERR with err_code=2.
  - If rx_done coincides with the expiry cycle, the byte wins and the timeout is not taken.
- ERR: load_err=1, busy=0, cpu_reset stays 1. The state is left only by SYNC_BYTE or reset.
- In RUN, a SYNC_BYTE re-asserts cpu_reset the next cycle and starts a new load.
- Byte values equal to SYNC_BYTE inside LEN and DATA are ordinary data.

Decomposition:
- Package uart_loader_pkg holds:
  - the state enum;
  - err_code constants ERR_NONE, ERR_LEN, ERR_TIMEOUT, ERR_CSUM;
  - the default SYNC_BYTE.
- One sub-module, loader_timeout, is natural: a parameterised inter-byte watchdog with a clear input and an expired output, counter width $clog2(TIMEOUT_CLKS+1).
- Everything else lives in one FSM module.

Test Plan:
- Normal load, TIMEOUT_CLKS=50:
  - Stimulus: bytes A5, 03, 11, 22, 33, 66.
  - Memory: writes 11@0, 22@1, 33@2, one cycle after each strobe.
  - Status: load_ok=1, err_code=0, cpu_reset falls one cycle after the 66 strobe.
- Checksum error:
  - Stimulus: A5, 02, 10, 20, 31.
  - Response: two writes, then load_err=1, err_code=3, cpu_reset stays 1.
  - Recovery: a following A5, 01, 7F, 7F gives load_ok=1 and a write of 7F@0.
- Bad length:
  - Stimulus: A5, 00.
  - Response: err_code=1, no mem_we.
- Timeout:
  - Stimulus: A5, 04, 01, then silence.
  - Response: err_code=2 exactly 50 clocks after the 01 strobe.
  - Boundary: a byte arriving on clock 50 keeps the load alive.
- Reload and reset:
  - While in RUN, send A5; cpu_reset goes to 1 the next cycle.
  - Assert reset after 2 payload bytes; all outputs return to their reset values and the next A5 starts a clean load at address 0.
- Data equal to sync:
  - Stimulus: A5, 02, A5, A5, 4A.
  - Response: writes A5@0, A5@1, load_ok=1.
